// File: rtl/packet_filter_ctrl.sv
// RX packet-filter sequencer for x1 lanes: parses STP/SDP framing tokens from a
// byte stream and drives buffer writes in 31-byte chunks with chunk-done pulses.
module packet_filter_ctrl #(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_PTR_WIDTH = 5,
  parameter int CHUNK_BYTES      = 31
) (
  input  logic                        CLK,
  input  logic                        RST_L,
  input  logic                        i_Valid,
  input  logic [SYMBOL_WIDTH-1:0]     i_Sym,
  input  logic                        i_STP,
  input  logic                        i_SDP,
  output logic [SYMBOL_PTR_WIDTH-1:0] o_Address,
  output logic [1:0]                  o_Data_W_Options,
  output logic [SYMBOL_WIDTH-1:0]     o_Data,
  output logic                        o_Data_W_EN,
  output logic                        o_SOP_W_EN,
  output logic                        o_SOP,
  output logic                        o_Ind_W_EN,
  output logic [PACKET_LENGTH-1:0]    o_Length,
  output logic                        o_Type,
  output logic                        o_Chunk_Valid,
  output logic [4:0]                  o_Chunk_Bytes,
  output logic                        o_Chunk_Last,
  output logic                        o_Frame_Err
);

  localparam int CNT_W = PACKET_LENGTH + 2;
  localparam int HI_W  = PACKET_LENGTH - SYMBOL_WIDTH;
  localparam logic [SYMBOL_PTR_WIDTH-1:0] PTR_ZERO = {SYMBOL_PTR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TOK1    = 2'd1,
    SKIP    = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [HI_W-1:0]             byte0_q, byte0_d;
  logic                        is_tlp_q, is_tlp_d;
  logic                        skip_q, skip_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [SYMBOL_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                        first_q, first_d;
  logic                        close_q, close_d;
  logic [4:0]                  close_bytes_q, close_bytes_d;
  logic                        close_last_q, close_last_d;

  logic [SYMBOL_PTR_WIDTH-1:0] addr_q, addr_d;
  logic [SYMBOL_WIDTH-1:0]     data_q, data_d;
  logic                        data_w_en_q, data_w_en_d;
  logic                        sop_w_en_q, sop_w_en_d;
  logic                        sop_q, sop_d;
  logic                        ind_w_en_q, ind_w_en_d;
  logic [PACKET_LENGTH-1:0]    length_q, length_d;
  logic                        type_q, type_d;
  logic                        chunk_valid_q, chunk_valid_d;
  logic [4:0]                  chunk_bytes_q, chunk_bytes_d;
  logic                        chunk_last_q, chunk_last_d;
  logic                        frame_err_q, frame_err_d;

  logic [PACKET_LENGTH-1:0]    tok_len_s;
  logic                        token_s;
  logic                        chunk_end_s;
  logic                        last_byte_s;

  assign tok_len_s   = PACKET_LENGTH'({byte0_q, i_Sym});
  assign token_s     = i_STP | i_SDP;
  assign chunk_end_s = (wr_ptr_q == SYMBOL_PTR_WIDTH'(CHUNK_BYTES - 1));
  assign last_byte_s = (count_q == CNT_W'(1));

  // Next-state, parse and output decode; a closed chunk is announced one cycle after its last write.
  always_comb begin
    state_d       = state_q;
    byte0_d       = byte0_q;
    is_tlp_d      = is_tlp_q;
    skip_d        = skip_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    first_d       = first_q;
    close_d       = 1'b0;
    close_bytes_d = close_bytes_q;
    close_last_d  = close_last_q;
    addr_d        = addr_q;
    data_d        = data_q;
    data_w_en_d   = 1'b0;
    sop_w_en_d    = 1'b0;
    sop_d         = 1'b0;
    ind_w_en_d    = 1'b0;
    length_d      = length_q;
    type_d        = type_q;
    frame_err_d   = 1'b0;
    chunk_valid_d = close_q;
    chunk_bytes_d = close_q ? close_bytes_q : 5'd0;
    chunk_last_d  = close_q & close_last_q;

    if (i_Valid) begin
      case (state_q)
        IDLE: begin
          if (i_STP) begin
            byte0_d  = i_Sym[HI_W-1:0];
            is_tlp_d = 1'b1;
            state_d  = TOK1;
          end else if (i_SDP) begin
            is_tlp_d = 1'b0;
            state_d  = TOK1;
          end else begin
            state_d = IDLE;
          end
        end
        TOK1: begin
          if (token_s) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (is_tlp_q) begin
            if (tok_len_s < PACKET_LENGTH'(2)) begin
              frame_err_d = 1'b1;
              state_d     = IDLE;
            end else begin
              ind_w_en_d = 1'b1;
              length_d   = tok_len_s;
              type_d     = 1'b1;
              count_d    = {tok_len_s, 2'b00} - CNT_W'(4);
              skip_d     = 1'b0;
              wr_ptr_d   = PTR_ZERO;
              first_d    = 1'b1;
              state_d    = SKIP;
            end
          end else begin
            ind_w_en_d = 1'b1;
            length_d   = PACKET_LENGTH'(2);
            type_d     = 1'b0;
            count_d    = CNT_W'(6);
            wr_ptr_d   = PTR_ZERO;
            first_d    = 1'b1;
            state_d    = PAYLOAD;
          end
        end
        SKIP: begin
          if (token_s) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (skip_q) begin
            state_d = PAYLOAD;
          end else begin
            skip_d = 1'b1;
          end
        end
        PAYLOAD: begin
          if (token_s) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            data_w_en_d = 1'b1;
            addr_d      = wr_ptr_q;
            data_d      = i_Sym;
            if (wr_ptr_q == PTR_ZERO) begin
              sop_w_en_d = 1'b1;
              sop_d      = first_q;
            end else begin
              sop_w_en_d = 1'b0;
            end
            first_d = 1'b0;
            count_d = count_q - CNT_W'(1);
            if (chunk_end_s || last_byte_s) begin
              close_d       = 1'b1;
              close_bytes_d = 5'(wr_ptr_q) + 5'd1;
              close_last_d  = last_byte_s;
              wr_ptr_d      = PTR_ZERO;
            end else begin
              wr_ptr_d = wr_ptr_q + SYMBOL_PTR_WIDTH'(1);
            end
            if (last_byte_s) begin
              state_d = IDLE;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      state_q       <= IDLE;
      byte0_q       <= {HI_W{1'b0}};
      is_tlp_q      <= 1'b0;
      skip_q        <= 1'b0;
      count_q       <= {CNT_W{1'b0}};
      wr_ptr_q      <= PTR_ZERO;
      first_q       <= 1'b0;
      close_q       <= 1'b0;
      close_bytes_q <= 5'd0;
      close_last_q  <= 1'b0;
      addr_q        <= PTR_ZERO;
      data_q        <= {SYMBOL_WIDTH{1'b0}};
      data_w_en_q   <= 1'b0;
      sop_w_en_q    <= 1'b0;
      sop_q         <= 1'b0;
      ind_w_en_q    <= 1'b0;
      length_q      <= {PACKET_LENGTH{1'b0}};
      type_q        <= 1'b0;
      chunk_valid_q <= 1'b0;
      chunk_bytes_q <= 5'd0;
      chunk_last_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte0_q       <= byte0_d;
      is_tlp_q      <= is_tlp_d;
      skip_q        <= skip_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      first_q       <= first_d;
      close_q       <= close_d;
      close_bytes_q <= close_bytes_d;
      close_last_q  <= close_last_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      data_w_en_q   <= data_w_en_d;
      sop_w_en_q    <= sop_w_en_d;
      sop_q         <= sop_d;
      ind_w_en_q    <= ind_w_en_d;
      length_q      <= length_d;
      type_q        <= type_d;
      chunk_valid_q <= chunk_valid_d;
      chunk_bytes_q <= chunk_bytes_d;
      chunk_last_q  <= chunk_last_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign o_Address        = addr_q;
  assign o_Data_W_Options = 2'd0;
  assign o_Data           = data_q;
  assign o_Data_W_EN      = data_w_en_q;
  assign o_SOP_W_EN       = sop_w_en_q;
  assign o_SOP            = sop_q;
  assign o_Ind_W_EN       = ind_w_en_q;
  assign o_Length         = length_q;
  assign o_Type           = type_q;
  assign o_Chunk_Valid    = chunk_valid_q;
  assign o_Chunk_Bytes    = chunk_bytes_q;
  assign o_Chunk_Last     = chunk_last_q;
  assign o_Frame_Err      = frame_err_q;

endmodule

// File: tb/tb_packet_filter_ctrl.sv
// Bench for packet_filter_ctrl: a hand-written vector table, directed packet
// sequences and a randomized stream checked against a packet-level reference model.
module tb_packet_filter_ctrl;

  logic        CLK = 1'b0;
  logic        RST_L = 1'b0;
  logic        i_Valid = 1'b0;
  logic [7:0]  i_Sym = 8'd0;
  logic        i_STP = 1'b0;
  logic        i_SDP = 1'b0;
  logic [4:0]  o_Address;
  logic [1:0]  o_Data_W_Options;
  logic [7:0]  o_Data;
  logic        o_Data_W_EN, o_SOP_W_EN, o_SOP, o_Ind_W_EN;
  logic [10:0] o_Length;
  logic        o_Type, o_Chunk_Valid;
  logic [4:0]  o_Chunk_Bytes;
  logic        o_Chunk_Last, o_Frame_Err;

  always #5 CLK = ~CLK;

  packet_filter_ctrl dut (
    .CLK(CLK), .RST_L(RST_L), .i_Valid(i_Valid), .i_Sym(i_Sym), .i_STP(i_STP), .i_SDP(i_SDP),
    .o_Address(o_Address), .o_Data_W_Options(o_Data_W_Options), .o_Data(o_Data),
    .o_Data_W_EN(o_Data_W_EN), .o_SOP_W_EN(o_SOP_W_EN), .o_SOP(o_SOP), .o_Ind_W_EN(o_Ind_W_EN),
    .o_Length(o_Length), .o_Type(o_Type), .o_Chunk_Valid(o_Chunk_Valid),
    .o_Chunk_Bytes(o_Chunk_Bytes), .o_Chunk_Last(o_Chunk_Last), .o_Frame_Err(o_Frame_Err)
  );

  typedef struct {
    bit         rst_n, valid, stp, sdp;
    logic [7:0] sym;
  } in_t;

  typedef struct {
    bit          wen;
    logic [4:0]  addr;
    logic [7:0]  data;
    bit          sopwen, sop, ind;
    logic [10:0] len;
    bit          typ, cv;
    logic [4:0]  cb;
    bit          cl, fe, zero;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  in_t  stim[$];
  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   obs_cb[$];
  bit   obs_cl[$];
  bit   obs_sop[$];
  int   obs_len[$];
  int   n_wr, n_fe;
  vec_t tbl[13];

  task automatic chk(string name, int t, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  function automatic in_t mk(bit rst_n, bit valid, bit stp, bit sdp, logic [7:0] sym);
    in_t s;
    s.rst_n = rst_n; s.valid = valid; s.stp = stp; s.sdp = sdp; s.sym = sym;
    return s;
  endfunction

  function automatic vec_t row(bit rst_n, bit valid, bit stp, bit sdp, logic [7:0] sym,
                               bit wen, int addr, bit sopwen, bit sop, bit ind, int len, bit typ,
                               bit cv, int cb, bit cl, bit fe);
    vec_t v;
    v.i = mk(rst_n, valid, stp, sdp, sym);
    v.e = '{default: 0};
    v.e.wen = wen; v.e.addr = 5'(addr); v.e.data = sym; v.e.sopwen = sopwen; v.e.sop = sop;
    v.e.ind = ind; v.e.len = 11'(len); v.e.typ = typ; v.e.cv = cv; v.e.cb = 5'(cb);
    v.e.cl = cl; v.e.fe = fe; v.e.zero = !rst_n;
    return v;
  endfunction

  task automatic apply(in_t s);
    RST_L = s.rst_n; i_Valid = s.valid; i_STP = s.stp; i_SDP = s.sdp; i_Sym = s.sym;
    @(posedge CLK);
    #1;
  endtask

  task automatic compare(string tag, int t, exp_t e);
    chk({tag, ".wen"},    t, 32'(o_Data_W_EN),      32'(e.wen));
    chk({tag, ".sopwen"}, t, 32'(o_SOP_W_EN),       32'(e.sopwen));
    chk({tag, ".sop"},    t, 32'(o_SOP),            32'(e.sop));
    chk({tag, ".ind"},    t, 32'(o_Ind_W_EN),       32'(e.ind));
    chk({tag, ".cvalid"}, t, 32'(o_Chunk_Valid),    32'(e.cv));
    chk({tag, ".cbytes"}, t, 32'(o_Chunk_Bytes),    32'(e.cb));
    chk({tag, ".clast"},  t, 32'(o_Chunk_Last),     32'(e.cl));
    chk({tag, ".ferr"},   t, 32'(o_Frame_Err),      32'(e.fe));
    chk({tag, ".wopt"},   t, 32'(o_Data_W_Options), 32'd0);
    if (e.wen || e.zero) begin
      chk({tag, ".addr"}, t, 32'(o_Address), 32'(e.addr));
      chk({tag, ".data"}, t, 32'(o_Data),    e.zero ? 32'd0 : 32'(e.data));
    end
    if (e.ind || e.zero) begin
      chk({tag, ".len"},  t, 32'(o_Length), 32'(e.len));
      chk({tag, ".type"}, t, 32'(o_Type),   32'(e.typ));
    end
  endtask

  task automatic observe();
    if (o_Chunk_Valid) begin obs_cb.push_back(int'(o_Chunk_Bytes)); obs_cl.push_back(o_Chunk_Last); end
    if (o_SOP_W_EN) obs_sop.push_back(o_SOP);
    if (o_Ind_W_EN) obs_len.push_back(int'(o_Length));
    if (o_Data_W_EN) n_wr++;
    if (o_Frame_Err) n_fe++;
  endtask

  task automatic junk();
    stim.push_back(mk(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom)));
  endtask

  // gap < 0: random 0..2 idle cycles after the byte
  task automatic push_b(bit stp, bit sdp, logic [7:0] sym, int gap);
    int g;
    stim.push_back(mk(1'b1, 1'b1, stp, sdp, sym));
    g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
    repeat (g) junk();
  endtask

  // cut >= 0: after 'cut' bytes following byte 0, inject a stray token (or a reset) and stop
  task automatic add_pkt(bit tlp, int len, int gap, int cut, bit cut_rst);
    logic [10:0] l;
    logic [7:0]  b;
    int          n;
    l = 11'(len);
    if (tlp) begin
      push_b(1'b1, 1'($urandom), {5'($urandom), l[10:8]}, gap);
      n = (len < 2) ? 1 : 4 * len - 1;
    end else begin
      push_b(1'b0, 1'b1, 8'($urandom), gap);
      n = 7;
    end
    for (int idx = 0; idx < n; idx++) begin
      if (idx == cut) begin
        if (cut_rst) stim.push_back(mk(1'b0, 1'($urandom), 1'b0, 1'b0, 8'($urandom)));
        else push_b(1'($urandom), 1'b1, 8'($urandom), gap);
        return;
      end
      b = (tlp && idx == 0) ? l[7:0] : 8'($urandom);
      push_b(1'b0, 1'b0, b, gap);
    end
  endtask

  // Reference model: tracks byte position k within a packet; payload index p gives
  // address p%31, chunk boundaries and SOP directly.
  task automatic build_expected();
    bit         in_pkt, tlp, pend, pend_l;
    int         k, hdr, total, pend_b, p, L;
    logic [2:0] b0;
    exp_t       e;
    in_pkt = 0; tlp = 0; pend = 0; pend_l = 0; k = 0; hdr = 0; total = 0; pend_b = 0; b0 = 3'd0;
    expq.delete();
    foreach (stim[t]) begin
      e = '{default: 0};
      if (!stim[t].rst_n) begin
        in_pkt = 0; pend = 0; e.zero = 1;
      end else begin
        if (pend) begin e.cv = 1; e.cb = 5'(pend_b); e.cl = pend_l; end
        pend = 0;
        if (stim[t].valid) begin
          if (!in_pkt) begin
            if (stim[t].stp) begin in_pkt = 1; tlp = 1; k = 1; b0 = stim[t].sym[2:0]; end
            else if (stim[t].sdp) begin in_pkt = 1; tlp = 0; k = 1; end
          end else if (stim[t].stp || stim[t].sdp) begin
            e.fe = 1; in_pkt = 0;
          end else if (k == 1) begin
            k = 2;
            if (tlp) begin
              L = int'({b0, stim[t].sym});
              if (L < 2) begin e.fe = 1; in_pkt = 0; end
              else begin e.ind = 1; e.len = 11'(L); e.typ = 1; total = 4 * L - 4; hdr = 4; end
            end else begin
              e.ind = 1; e.len = 11'd2; e.typ = 0; total = 6; hdr = 2;
            end
          end else begin
            p = k - hdr;
            k++;
            if (p >= 0) begin
              e.wen = 1; e.addr = 5'(p % 31); e.data = stim[t].sym;
              e.sopwen = (p % 31 == 0); e.sop = (p == 0);
              if (p % 31 == 30 || p == total - 1) begin
                pend = 1; pend_b = p % 31 + 1; pend_l = (p == total - 1);
              end
              if (p == total - 1) in_pkt = 0;
            end
          end
        end
      end
      expq.push_back(e);
    end
  endtask

  task automatic run_stream(string tag);
    build_expected();
    obs_cb.delete(); obs_cl.delete(); obs_sop.delete(); obs_len.delete();
    n_wr = 0; n_fe = 0;
    foreach (stim[t]) begin
      apply(stim[t]);
      compare(tag, t, expq[t]);
      observe();
    end
    stim.delete();
  endtask

  task automatic check_chunks(string tag, int n, int b0, bit l0, int b1, bit l1);
    chk({tag, ".nchunks"}, 0, 32'(obs_cb.size()), 32'(n));
    if (n >= 1 && obs_cb.size() >= 1) begin
      chk({tag, ".c0bytes"}, 0, 32'(obs_cb[0]), 32'(b0));
      chk({tag, ".c0last"},  0, 32'(obs_cl[0]), 32'(l0));
    end
    if (n >= 2 && obs_cb.size() >= 2) begin
      chk({tag, ".c1bytes"}, 0, 32'(obs_cb[1]), 32'(b1));
      chk({tag, ".c1last"},  0, 32'(obs_cl[1]), 32'(l1));
    end
  endtask

  initial begin
    tbl[0] = row(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = row(1, 1, 0, 1, 8'hC0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = row(1, 1, 0, 0, 8'hAC, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      tbl[3 + i] = row(1, 1, 0, 0, 8'(8'h10 + i), 1, i, i == 0, i == 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = row(1, 0, 1, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0);
    tbl[10] = row(1, 1, 1, 0, 8'hF8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = row(1, 1, 0, 0, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[12] = row(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].i);
      compare("tbl", i, tbl[i].e);
    end

    add_pkt(1'b1, 10, 0, -1, 1'b0);
    repeat (3) junk();
    run_stream("tlp10");
    check_chunks("tlp10", 2, 31, 1'b0, 5, 1'b1);
    chk("tlp10.nwr", 0, 32'(n_wr), 32'd36);
    chk("tlp10.nsop", 0, 32'(obs_sop.size()), 32'd2);
    if (obs_sop.size() == 2) begin
      chk("tlp10.sop0", 0, 32'(obs_sop[0]), 32'd1);
      chk("tlp10.sop1", 0, 32'(obs_sop[1]), 32'd0);
    end

    add_pkt(1'b1, 10, 1, -1, 1'b0);
    repeat (3) junk();
    run_stream("tlp10gap");
    check_chunks("tlp10gap", 2, 31, 1'b0, 5, 1'b1);
    chk("tlp10gap.nwr", 0, 32'(n_wr), 32'd36);

    add_pkt(1'b1, 0, 0, -1, 1'b0);
    add_pkt(1'b0, 0, 0, -1, 1'b0);
    repeat (3) junk();
    run_stream("len0");
    chk("len0.ferr", 0, 32'(n_fe), 32'd1);
    chk("len0.nind", 0, 32'(obs_len.size()), 32'd1);
    check_chunks("len0", 1, 6, 1'b1, 0, 1'b0);

    add_pkt(1'b1, 10, 0, 23, 1'b0);
    repeat (3) junk();
    add_pkt(1'b0, 0, 0, -1, 1'b0);
    repeat (3) junk();
    run_stream("sdpmid");
    chk("sdpmid.ferr", 0, 32'(n_fe), 32'd1);
    chk("sdpmid.nwr", 0, 32'(n_wr), 32'd26);
    check_chunks("sdpmid", 1, 6, 1'b1, 0, 1'b0);

    add_pkt(1'b1, 10, 0, 15, 1'b1);
    add_pkt(1'b1, 2, 0, -1, 1'b0);
    repeat (3) junk();
    run_stream("rstmid");
    check_chunks("rstmid", 1, 4, 1'b1, 0, 1'b0);
    chk("rstmid.nwr", 0, 32'(n_wr), 32'd16);

    for (int n = 0; n < 150; n++) begin
      int len, cut;
      bit tlp, crst;
      tlp  = ($urandom_range(9, 0) != 0);
      len  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(33, 31)) : int'($urandom_range(12, 0));
      cut  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(40, 0)) : -1;
      crst = ($urandom_range(3, 0) == 0);
      add_pkt(tlp, len, ($urandom_range(1, 0) == 1) ? -1 : 0, cut, crst);
      repeat ($urandom_range(2, 0)) push_b(1'b0, 1'b0, 8'($urandom), 0);
    end
    repeat (3) junk();
    run_stream("rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
